bin_to_bcd_seq: RTL

//  Sequential shift-add-3 (double-dabble) binary-to-BCD converter, directly downstream of
//  the Booth multiplier. Takes the multiplier's unsigned magnitude result plus sign flag and

---
 rtl/bin_to_bcd_seq.sv | 94 +++++++++
 1 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter: one input bit per clock,
// packed BCD plus a zero-suppressed sign delivered with a one-cycle ready pulse.
module bin_to_bcd_seq #(
  parameter int WORD_LENGTH = 16,
  parameter int DIGITS      = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [2*WORD_LENGTH-1:0] Result,
  input  logic                     sign,
  output logic                     busy,
  output logic                     ready,
  output logic [4*DIGITS-1:0]      bcd,
  output logic                     sign_out
);

  localparam int NB = 2 * WORD_LENGTH;
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(NB + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CONVERT = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  logic [1:0]    r_state;
  logic [NB-1:0] r_shift;
  logic [BW-1:0] r_scratch;
  logic [CW-1:0] r_cnt;
  logic          r_sign;
  logic [BW-1:0] r_bcd;
  logic          r_sign_out;

  logic [BW-1:0] w_scratch_nxt;
  logic          w_accept;
  logic          w_last;

  // Add-3 on every digit, then shift left by one: each digit's post-adjust MSB
  // carries into the next digit's LSB, the shift register MSB enters digit 0.
  always_comb begin
    logic [3:0] v_dig;
    logic       v_carry;
    w_scratch_nxt = '0;
    v_dig         = '0;
    v_carry       = r_shift[NB-1];
    for (int unsigned d = 0; d < DIGITS; d++) begin
      v_dig = r_scratch[4*d +: 4];
      if (v_dig >= 4'd5) v_dig = v_dig + 4'd3;
      w_scratch_nxt[4*d +: 4] = {v_dig[2:0], v_carry};
      v_carry = v_dig[3];
    end
  end

  assign w_accept = start && (r_state != S_CONVERT);
  assign w_last   = (r_cnt == CW'(NB - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_scratch  <= '0;
      r_cnt      <= '0;
      r_sign     <= 1'b0;
      r_bcd      <= '0;
      r_sign_out <= 1'b0;
    end else if (w_accept) begin
      r_shift   <= Result;
      r_sign    <= sign & (|Result);
      r_scratch <= '0;
      r_cnt     <= '0;
      r_state   <= S_CONVERT;
    end else begin
      case (r_state)
        S_CONVERT: begin
          r_scratch <= w_scratch_nxt;
          r_shift   <= {r_shift[NB-2:0], 1'b0};
          r_cnt     <= r_cnt + CW'(1);
          if (w_last) begin
            r_bcd      <= w_scratch_nxt;
            r_sign_out <= r_sign;
            r_state    <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy     = (r_state == S_CONVERT);
  assign ready    = (r_state == S_DONE);
  assign bcd      = r_bcd;
  assign sign_out = r_sign_out;

endmodule
